// File: rtl/cofi_blend_ctrl_if.sv
// cofi_blend_ctrl_if: bundle between the OSD/config side and the cofi blend
// controller.
//   master : drives the pixel stream, the blanking signals and the requested
//            settings. It observes the blender configuration.
//   slave  : the controller. It takes the stream and settings, and drives the
//            blender configuration, auto_state and stat_count.
// Parameter CNT_W must match the controller's CNT_W.
interface cofi_blend_ctrl_if #(
    parameter int unsigned CNT_W = 20
);
    logic             ce_pixel;
    logic             hblank;
    logic             vblank;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic [1:0]       mode;
    logic             hud_req;
    logic             debug_req;
    logic             force_all;
    logic             pattern_blend;
    logic             diff_blend;
    logic             hud_filter;
    logic             debug_view;
    logic             force_blend;
    logic             auto_state;
    logic [CNT_W-1:0] stat_count;

    modport master (
        output ce_pixel, hblank, vblank, red, green, blue,
        output mode, hud_req, debug_req, force_all,
        input  pattern_blend, diff_blend, hud_filter, debug_view,
        input  force_blend, auto_state, stat_count
    );

    modport slave (
        input  ce_pixel, hblank, vblank, red, green, blue,
        input  mode, hud_req, debug_req, force_all,
        output pattern_blend, diff_blend, hud_filter, debug_view,
        output force_blend, auto_state, stat_count
    );
endinterface

// File: rtl/cofi_blend_ctrl.sv
// cofi_blend_ctrl: frame-synchronous configuration controller for the cofi
// smart blender. User settings are latched only at the evaluation cycle that
// follows each vblank rising edge. In auto mode (mode==3) the controller
// counts alternating-pixel hits per frame, classifies each frame as dithered,
// clean or neutral, and toggles its auto decision after HYST_FRAMES
// consecutive frames of the opposite class.
// Ports:
//   clk    video clock
//   reset  synchronous, active-high
//   bus    cofi_blend_ctrl_if.slave:
//          inputs  ce_pixel, hblank, vblank, red/green/blue, mode,
//                  hud_req, debug_req, force_all
//          outputs pattern_blend, diff_blend, hud_filter, debug_view,
//                  force_blend, auto_state, stat_count
// Optional macro COFI_CTRL_STATS_EN: when it is defined, stat_count holds the
// saturated hit count of the last evaluated frame. Otherwise stat_count is
// tied to 0.
module cofi_blend_ctrl #(
    parameter int unsigned      CNT_W       = 20,
    parameter logic [CNT_W-1:0] ON_THRESH   = CNT_W'(4096),
    parameter logic [CNT_W-1:0] OFF_THRESH  = CNT_W'(1024),
    parameter int unsigned      HYST_FRAMES = 3
) (
    input logic              clk,
    input logic              reset,
    cofi_blend_ctrl_if.slave bus
);
    typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, EVAL} state_t;

    state_t           state_q;
    logic             vblank_q;
    logic [23:0]      p1_q, p2_q;
    logic             p1_vld_q, p2_vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       streak_q;
    logic             auto_q;
    logic             pattern_q, diff_q, hud_q, debug_q, force_lat_q;

    logic [23:0]      rgb;
    logic             vb_rise, pix_active, hit;
    logic [CNT_W-1:0] cnt_d;
    logic             opposite;
    logic [2:0]       streak_inc, streak_d;
    logic             auto_d, pattern_d, diff_d;

    always_comb begin
        rgb        = {bus.red, bus.green, bus.blue};
        vb_rise    = bus.vblank & ~vblank_q;
        pix_active = (state_q == ACTIVE) & ~bus.hblank & ~bus.vblank;
        // A valid p2 implies a valid p1, because history fills in order.
        hit        = pix_active & p2_vld_q & (rgb == p2_q) & (rgb != p1_q);

        cnt_d = cnt_q;
        if (hit && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Opposite class relative to the current decision. Neutral frames
        // never count as opposite.
        opposite   = auto_q ? (cnt_q < OFF_THRESH) : (cnt_q >= ON_THRESH);
        streak_inc = streak_q + 3'd1;
        streak_d   = '0;
        auto_d     = auto_q;
        if (bus.mode == 2'd3 && opposite) begin
            if (streak_inc == 3'(HYST_FRAMES)) begin
                auto_d = ~auto_q;
            end else begin
                streak_d = streak_inc;
            end
        end

        pattern_d = (bus.mode == 2'd1) | ((bus.mode == 2'd3) & auto_d);
        diff_d    = (bus.mode == 2'd2) | ((bus.mode == 2'd3) & ~auto_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_FRAME;
            vblank_q    <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            p1_vld_q    <= 1'b0;
            p2_vld_q    <= 1'b0;
            cnt_q       <= '0;
            streak_q    <= '0;
            auto_q      <= 1'b0;
            pattern_q   <= 1'b0;
            diff_q      <= 1'b0;
            hud_q       <= 1'b0;
            debug_q     <= 1'b0;
            force_lat_q <= 1'b0;
        end else if (bus.ce_pixel) begin
            vblank_q <= bus.vblank;

            // History never spans a line.
            if (bus.hblank) begin
                p1_vld_q <= 1'b0;
                p2_vld_q <= 1'b0;
            end else if (pix_active) begin
                p2_q     <= p1_q;
                p2_vld_q <= p1_vld_q;
                p1_q     <= rgb;
                p1_vld_q <= 1'b1;
            end

            case (state_q)
                WAIT_FRAME: begin
                    if (vb_rise) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    cnt_q <= cnt_d;
                    if (vb_rise) begin
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    streak_q    <= streak_d;
                    auto_q      <= auto_d;
                    pattern_q   <= pattern_d;
                    diff_q      <= diff_d;
                    hud_q       <= bus.hud_req & pattern_d;
                    debug_q     <= bus.debug_req;
                    force_lat_q <= bus.force_all;
                    cnt_q       <= '0;
                    state_q     <= ACTIVE;
                end
                default: begin
                    state_q <= WAIT_FRAME;
                end
            endcase
        end
    end

`ifdef COFI_CTRL_STATS_EN
    logic [CNT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= '0;
        end else if (bus.ce_pixel && state_q == EVAL) begin
            stat_q <= cnt_q;
        end
    end

    assign bus.stat_count = stat_q;
`else
    assign bus.stat_count = '0;
`endif

    assign bus.pattern_blend = pattern_q;
    assign bus.diff_blend    = diff_q;
    assign bus.hud_filter    = hud_q;
    assign bus.debug_view    = debug_q;
    assign bus.auto_state    = auto_q;
    assign bus.force_blend   = force_lat_q & ~bus.hblank & ~bus.vblank;

endmodule

// File: tb/tb_cofi_blend_ctrl.sv
// Testbench for cofi_blend_ctrl. It uses reduced frame and threshold sizes:
// 16 pixels per line, 8 lines, CNT_W=8, ON=36, OFF=10, HYST=3.
module tb_cofi_blend_ctrl;
    localparam int W   = 16;
    localparam int HBL = 4;
    localparam int VBL = 2;
    localparam int CW  = 8;
    localparam int ON  = 36;
    localparam int OFF = 10;
    localparam int HY  = 3;
    localparam int SATV = (1 << CW) - 1;

    localparam int K_CHECK = 0;
    localparam int K_FLAT  = 1;
    localparam int K_SPAN  = 2;
    localparam int K_RAND  = 3;
    localparam int K_SAT   = 4;

    typedef struct {
        int kind; int lines; int mode; int hud; int dbg; int frc;
        int e_auto; int e_pat; int e_diff; int e_hud; int e_dbg; int e_frc; int e_stat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   frame_hits;
    int   pal = 2;
    logic [23:0] line_buf [W];
    vec_t tbl [22];
    int   m_auto, m_run;

    cofi_blend_ctrl_if #(.CNT_W(CW)) bus ();

    cofi_blend_ctrl #(
        .CNT_W(CW),
        .ON_THRESH(8'd36),
        .OFF_THRESH(8'd10),
        .HYST_FRAMES(HY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(int kind, int lines, int mode, int hud, int dbg, int frc,
                                int e_auto, int e_pat, int e_diff, int e_hud, int e_dbg,
                                int e_frc, int e_stat);
        vec_t v;
        v.kind = kind; v.lines = lines; v.mode = mode; v.hud = hud; v.dbg = dbg; v.frc = frc;
        v.e_auto = e_auto; v.e_pat = e_pat; v.e_diff = e_diff; v.e_hud = e_hud;
        v.e_dbg = e_dbg; v.e_frc = e_frc; v.e_stat = e_stat;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One ce_pixel-qualified pixel. It is preceded by a random number of
    // ce-low cycles that carry junk on the stream.
    task automatic px(input logic hb, input logic vb, input logic [23:0] rgb);
        while ($urandom_range(3) == 0) begin
            bus.ce_pixel = 1'b0;
            bus.hblank   = 1'($urandom_range(1));
            bus.vblank   = 1'($urandom_range(1));
            {bus.red, bus.green, bus.blue} = 24'($urandom);
            @(posedge clk); #1;
        end
        bus.ce_pixel = 1'b1;
        bus.hblank   = hb;
        bus.vblank   = vb;
        {bus.red, bus.green, bus.blue} = rgb;
        @(posedge clk); #1;
    endtask

    function automatic logic [23:0] span_pix(int i);
        case (i)
            0, 2, 4: return 24'h0000AA;
            1, 3, 5: return 24'h0000DD;
            14:      return 24'h0000AA;
            15:      return 24'h0000BB;
            default: return 24'h0000EE;
        endcase
    endfunction

    task automatic fill_line(input int kind, input int l);
        for (int i = 0; i < W; i++) begin
            case (kind)
                K_CHECK: line_buf[i] = (i % 2 == 0) ? 24'h000000 : 24'hFFFFFF;
                K_FLAT:  line_buf[i] = 24'h123456;
                K_SPAN:  line_buf[i] = span_pix(i);
                K_SAT:   line_buf[i] = (l < 18) ? ((i % 2 == 0) ? 24'h000000 : 24'hFFFFFF)
                                                : span_pix(i);
                default: line_buf[i] = 24'($urandom_range(pal - 1));
            endcase
        end
    endtask

    // Reference rule: within one line, a pixel is a hit when it equals the
    // pixel two back and differs from the previous one.
    function automatic int line_hits();
        int h = 0;
        for (int i = 2; i < W; i++)
            if (line_buf[i] == line_buf[i-2] && line_buf[i] != line_buf[i-1]) h++;
        return h;
    endfunction

    task automatic send_active(input int kind, input int lines);
        for (int l = 0; l < lines; l++) begin
            fill_line(kind, l);
            frame_hits += line_hits();
            for (int i = 0; i < W; i++) px(1'b0, 1'b0, line_buf[i]);
            for (int h = 0; h < HBL; h++) px(1'b1, 1'b0, 24'h0);
        end
    endtask

    task automatic send_vblank(input int skip);
        for (int n = skip; n < VBL * (W + HBL); n++)
            px((n % (W + HBL)) >= W, 1'b1, 24'h0);
    endtask

    task automatic check_outputs(input string tag, input int e_auto, input int e_pat,
                                 input int e_diff, input int e_hud, input int e_dbg,
                                 input int e_frc, input int e_stat);
        int es;
        bus.ce_pixel = 1'b0;
        bus.hblank   = 1'b0;
        bus.vblank   = 1'b0;
        #1;
`ifdef COFI_CTRL_STATS_EN
        es = e_stat;
`else
        es = 0 * e_stat;
`endif
        chk({tag, ".auto_state"},    int'(bus.auto_state),    e_auto);
        chk({tag, ".pattern_blend"}, int'(bus.pattern_blend), e_pat);
        chk({tag, ".diff_blend"},    int'(bus.diff_blend),    e_diff);
        chk({tag, ".hud_filter"},    int'(bus.hud_filter),    e_hud);
        chk({tag, ".debug_view"},    int'(bus.debug_view),    e_dbg);
        chk({tag, ".force_blend"},   int'(bus.force_blend),   e_frc);
        chk({tag, ".stat_count"},    int'(bus.stat_count),    es);
    endtask

    initial begin
        //           kind     ln mode hud dbg frc  auto pat diff hud dbg frc stat
        tbl[0]  = mk(K_CHECK,  8, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(K_CHECK,  8, 3, 1, 0, 0,   0, 0, 1, 0, 0, 0, 112);
        tbl[2]  = mk(K_CHECK,  8, 3, 1, 1, 0,   0, 0, 1, 0, 1, 0, 112);
        tbl[3]  = mk(K_CHECK,  8, 3, 1, 1, 0,   1, 1, 0, 1, 1, 0, 112);
        tbl[4]  = mk(K_FLAT,   8, 3, 1, 0, 0,   1, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(K_FLAT,   8, 3, 1, 0, 0,   1, 1, 0, 1, 0, 0, 0);
        tbl[6]  = mk(K_FLAT,   8, 3, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(K_SPAN,   8, 3, 0, 0, 0,   0, 0, 1, 0, 0, 0, 32);
        tbl[8]  = mk(K_SPAN,   8, 3, 0, 0, 0,   0, 0, 1, 0, 0, 0, 32);
        tbl[9]  = mk(K_SPAN,   8, 3, 0, 0, 0,   0, 0, 1, 0, 0, 0, 32);
        tbl[10] = mk(K_SAT,   20, 3, 0, 0, 0,   0, 0, 1, 0, 0, 0, SATV);
        tbl[11] = mk(K_SAT,   20, 3, 0, 0, 0,   0, 0, 1, 0, 0, 0, SATV);
        tbl[12] = mk(K_SAT,   20, 3, 0, 0, 0,   1, 1, 0, 0, 0, 0, SATV);
        tbl[13] = mk(K_CHECK,  8, 2, 1, 0, 1,   1, 0, 1, 0, 0, 1, 112);
        tbl[14] = mk(K_FLAT,   8, 2, 0, 0, 1,   1, 0, 1, 0, 0, 1, 0);
        tbl[15] = mk(K_FLAT,   8, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(K_FLAT,   8, 3, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(K_FLAT,   8, 3, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[18] = mk(K_CHECK,  8, 3, 0, 0, 0,   1, 1, 0, 0, 0, 0, 112);
        tbl[19] = mk(K_FLAT,   8, 3, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[20] = mk(K_FLAT,   8, 3, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[21] = mk(K_FLAT,   8, 3, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);

        reset = 1'b1;
        bus.ce_pixel = 1'b1; bus.hblank = 1'b0; bus.vblank = 1'b0;
        {bus.red, bus.green, bus.blue} = 24'h0;
        bus.mode = 2'd3; bus.hud_req = 1'b0; bus.debug_req = 1'b0; bus.force_all = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Table-driven frames. Each row is checked after the EVAL that
        // follows it.
        for (int r = 0; r < 22; r++) begin
            bus.mode      = 2'(tbl[r].mode);
            bus.hud_req   = 1'(tbl[r].hud);
            bus.debug_req = 1'(tbl[r].dbg);
            bus.force_all = 1'(tbl[r].frc);
            frame_hits = 0;
            send_active(tbl[r].kind, tbl[r].lines);
            send_vblank(0);
            check_outputs($sformatf("row%0d", r), tbl[r].e_auto, tbl[r].e_pat, tbl[r].e_diff,
                          tbl[r].e_hud, tbl[r].e_dbg, tbl[r].e_frc, tbl[r].e_stat);
        end

        // Settings change mid-frame take effect one ce_pixel after the vblank edge.
        bus.mode = 2'd3; bus.hud_req = 1'b0;
        send_active(K_FLAT, 4);
        bus.mode = 2'd1; bus.hud_req = 1'b1;
        send_active(K_FLAT, 4);
        chk("midframe.pattern_before", int'(bus.pattern_blend), 0);
        chk("midframe.hud_before",     int'(bus.hud_filter),    0);
        px(1'b0, 1'b1, 24'h0);
        chk("vbedge.pattern", int'(bus.pattern_blend), 0);
        chk("vbedge.hud",     int'(bus.hud_filter),    0);
        px(1'b0, 1'b1, 24'h0);
        chk("eval.pattern", int'(bus.pattern_blend), 1);
        chk("eval.hud",     int'(bus.hud_filter),    1);
        chk("eval.diff",    int'(bus.diff_blend),    0);
        send_vblank(2);

        // A one-cycle reset mid-frame discards that frame entirely.
        bus.force_all = 1'b1;
        frame_hits = 0;
        send_active(K_CHECK, 8);
        send_vblank(0);
        send_active(K_CHECK, 3);
        bus.hblank = 1'b0; bus.vblank = 1'b0; bus.ce_pixel = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_outputs("midreset", 0, 0, 0, 0, 0, 0, 0);
        send_active(K_CHECK, 5);
        send_vblank(0);
        check_outputs("partial", 0, 0, 0, 0, 0, 0, 0);
        frame_hits = 0;
        send_active(K_CHECK, 8);
        send_vblank(0);
        check_outputs("firstfull", 0, 1, 0, 1, 0, 1, 112);

        // Randomized frames checked against the reference model.
        m_auto = 0;
        m_run  = 0;
        for (int r = 0; r < 16; r++) begin
            int kind;
            int md;
            int cnt;
            kind = $urandom_range(3);
            pal  = 2 + $urandom_range(1);
            md   = ($urandom_range(1) == 1) ? 3 : $urandom_range(3);
            bus.mode      = 2'(md);
            bus.hud_req   = 1'($urandom_range(1));
            bus.debug_req = 1'($urandom_range(1));
            bus.force_all = 1'($urandom_range(1));
            frame_hits = 0;
            send_active(kind, 8);
            cnt = (frame_hits > SATV) ? SATV : frame_hits;
            if (md == 3 && ((m_auto == 1 && cnt < OFF) || (m_auto == 0 && cnt >= ON))) begin
                m_run++;
                if (m_run == HY) begin
                    m_auto = 1 - m_auto;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            begin
                int ep;
                int ed;
                ep = (md == 1 || (md == 3 && m_auto == 1)) ? 1 : 0;
                ed = (md == 2 || (md == 3 && m_auto == 0)) ? 1 : 0;
                send_vblank(0);
                check_outputs($sformatf("rand%0d", r), m_auto, ep, ed,
                              ep & int'(bus.hud_req), int'(bus.debug_req),
                              int'(bus.force_all), cnt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
